// File: rtl/rv_ctl_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, mux selects,
// ALU op codes, FSM states and the control-output bundle.
package rv_ctl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic       PC_PLUS4  = 1'b0;
    localparam logic       PC_ALU    = 1'b1;

    localparam logic [1:0] WB_MDR    = 2'd0;
    localparam logic [1:0] WB_ALUOUT = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;

    localparam logic [1:0] IMM_J     = 2'd0;
    localparam logic [1:0] IMM_B     = 2'd1;
    localparam logic [1:0] IMM_S     = 2'd2;
    localparam logic [1:0] IMM_L     = 2'd3;

    localparam logic       ALUA_REG  = 1'b0;
    localparam logic       ALUA_PCC  = 1'b1;
    localparam logic       ALUB_REG  = 1'b0;
    localparam logic       ALUB_IMM  = 1'b1;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_BRANCH,
        S_JAL,
        S_HALT
    } state_t;

    typedef struct packed {
        logic       pcsourse;
        logic       pcwrite;
        logic       pccen;
        logic       irwrite;
        logic       regwen;
        logic       mdrwrite;
        logic       memwrite;
        logic [1:0] wbsel;
        logic [1:0] immsel;
        logic       asel;
        logic       bsel;
        logic [3:0] alusel;
        logic       illegal;
    } ctl_t;

endpackage

// File: rtl/rv_alu_dec.sv
// ALU operation decoder: maps funct3/funct7 to an ALU op and flags
// funct combinations this core does not implement (srai included).
module rv_alu_dec
    import rv_ctl_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic [6:0] i_funct7,
    input  logic       i_is_rtype,
    input  logic       i_is_opimm,
    output logic [3:0] o_alusel,
    output logic       o_illegal_funct
);

    logic w_alt;
    logic w_f7_zero;
    logic w_f7_alt;

    assign w_alt     = i_is_rtype && i_funct7[5];
    assign w_f7_zero = (i_funct7 == 7'h00);
    assign w_f7_alt  = (i_funct7 == 7'h20);

    always_comb begin
        o_alusel = ALU_ADD;
        unique case (i_funct3)
            3'b000: o_alusel = w_alt ? ALU_SUB : ALU_ADD;
            3'b001: o_alusel = ALU_SLL;
            3'b010: o_alusel = ALU_SLT;
            3'b011: o_alusel = ALU_SLTU;
            3'b100: o_alusel = ALU_XOR;
            3'b101: o_alusel = w_alt ? ALU_SRA : ALU_SRL;
            3'b110: o_alusel = ALU_OR;
            3'b111: o_alusel = ALU_AND;
            default: o_alusel = ALU_ADD;
        endcase
    end

    // Immediate shifts carry funct7 in imm[11:5]; only the logical forms exist here.
    always_comb begin
        o_illegal_funct = 1'b0;
        if (i_is_rtype) begin
            o_illegal_funct = !(w_f7_zero ||
                (w_f7_alt && (i_funct3 == 3'b000 || i_funct3 == 3'b101)));
        end else if (i_is_opimm &&
                     (i_funct3 == 3'b001 || i_funct3 == 3'b101)) begin
            o_illegal_funct = !w_f7_zero;
        end
    end

endmodule

// File: rtl/rv_ctl.sv
// Multicycle control FSM, instruction decode and retired-instruction counter.
// Define RV_CTL_ILLEGAL_HALT_EN to park in HALT on an illegal instruction.
module rv_ctl
    import rv_ctl_pkg::*;
#(
    parameter int DPWIDTH = 32
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic [DPWIDTH-1:0] instr,
    input  logic               zero,
    output logic               pcsourse,
    output logic               pcwrite,
    output logic               pccen,
    output logic               irwrite,
    output logic               regwen,
    output logic               mdrwrite,
    output logic               memwrite,
    output logic [1:0]         wbsel,
    output logic [1:0]         immsel,
    output logic               asel,
    output logic               bsel,
    output logic [3:0]         alusel,
    output logic               illegal,
    output logic [DPWIDTH-1:0] instret
);

    state_t             r_state;
    state_t             w_next;
    logic [DPWIDTH-1:0] r_instret;
    ctl_t               w_ctl;

    logic [6:0] w_op;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic       w_is_r, w_is_i, w_is_ld, w_is_st, w_is_br, w_is_jal;
    logic       w_legal;
    logic       w_illegal_funct;
    logic [3:0] w_alusel;
    logic       w_retire;
    logic       w_unused;

    assign w_op     = instr[6:0];
    assign w_f3     = instr[14:12];
    assign w_f7     = instr[31:25];
    assign w_unused = &{1'b0, instr[24:15], instr[11:7]};

    assign w_is_r   = (w_op == OP_R);
    assign w_is_i   = (w_op == OP_IMM);
    assign w_is_ld  = (w_op == OP_LOAD);
    assign w_is_st  = (w_op == OP_STORE);
    assign w_is_br  = (w_op == OP_BRANCH);
    assign w_is_jal = (w_op == OP_JAL);

    rv_alu_dec u_alu_dec (
        .i_funct3        (w_f3),
        .i_funct7        (w_f7),
        .i_is_rtype      (w_is_r),
        .i_is_opimm      (w_is_i),
        .o_alusel        (w_alusel),
        .o_illegal_funct (w_illegal_funct)
    );

    always_comb begin
        w_legal = 1'b0;
        unique case (1'b1)
            w_is_r, w_is_i:   w_legal = !w_illegal_funct;
            w_is_ld, w_is_st: w_legal = (w_f3 == 3'b010);
            w_is_br:          w_legal = (w_f3[2:1] == 2'b00);
            w_is_jal:         w_legal = 1'b1;
            default:          w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                if (!w_legal) begin
`ifdef RV_CTL_ILLEGAL_HALT_EN
                    w_next = S_HALT;
`else
                    w_next = S_FETCH;
`endif
                end else begin
                    unique case (1'b1)
                        w_is_r:           w_next = S_EXEC_R;
                        w_is_i:           w_next = S_EXEC_I;
                        w_is_ld, w_is_st: w_next = S_MEM_ADDR;
                        w_is_br:          w_next = S_BRANCH;
                        w_is_jal:         w_next = S_JAL;
                        default:          w_next = S_FETCH;
                    endcase
                end
            end
            S_EXEC_R, S_EXEC_I: w_next = S_ALU_WB;
            S_MEM_ADDR: w_next = w_is_st ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   w_next = S_MEM_WB;
            S_ALU_WB, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JAL:
                        w_next = S_FETCH;
            S_HALT:     w_next = S_HALT;
            default:    w_next = S_FETCH;
        endcase
    end

    // Final cycle of every legal instruction; illegal NOPs leave from DECODE.
    assign w_retire = r_state inside {S_ALU_WB, S_MEM_WB, S_MEM_WR,
                                      S_BRANCH, S_JAL};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire)
                r_instret <= r_instret + {{(DPWIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        w_ctl = '0;
        unique case (r_state)
            S_FETCH: begin
                w_ctl.irwrite  = 1'b1;
                w_ctl.pccen    = 1'b1;
                w_ctl.pcwrite  = 1'b1;
                w_ctl.pcsourse = PC_PLUS4;
            end
            S_DECODE: begin
                w_ctl.asel    = ALUA_PCC;
                w_ctl.bsel    = ALUB_IMM;
                w_ctl.alusel  = ALU_ADD;
                w_ctl.immsel  = w_is_jal ? IMM_J : IMM_B;
                w_ctl.illegal = !w_legal;
            end
            S_EXEC_R: begin
                w_ctl.asel   = ALUA_REG;
                w_ctl.bsel   = ALUB_REG;
                w_ctl.alusel = w_alusel;
            end
            S_EXEC_I: begin
                w_ctl.asel   = ALUA_REG;
                w_ctl.bsel   = ALUB_IMM;
                w_ctl.immsel = IMM_L;
                w_ctl.alusel = w_alusel;
            end
            S_ALU_WB: begin
                w_ctl.wbsel  = WB_ALUOUT;
                w_ctl.regwen = 1'b1;
            end
            S_MEM_ADDR: begin
                w_ctl.asel   = ALUA_REG;
                w_ctl.bsel   = ALUB_IMM;
                w_ctl.alusel = ALU_ADD;
                w_ctl.immsel = w_is_st ? IMM_S : IMM_L;
            end
            S_MEM_RD: w_ctl.mdrwrite = 1'b1;
            S_MEM_WB: begin
                w_ctl.wbsel  = WB_MDR;
                w_ctl.regwen = 1'b1;
            end
            S_MEM_WR: w_ctl.memwrite = 1'b1;
            S_BRANCH: begin
                w_ctl.asel     = ALUA_REG;
                w_ctl.bsel     = ALUB_REG;
                w_ctl.alusel   = ALU_SUB;
                w_ctl.pcsourse = PC_ALU;
                w_ctl.pcwrite  = w_f3[0] ? !zero : zero;
            end
            S_JAL: begin
                w_ctl.wbsel    = WB_PC;
                w_ctl.regwen   = 1'b1;
                w_ctl.pcwrite  = 1'b1;
                w_ctl.pcsourse = PC_ALU;
            end
            S_HALT:  w_ctl.illegal = 1'b1;
            default: w_ctl = '0;
        endcase
        if (rst)
            w_ctl = '0;
    end

    assign pcsourse = w_ctl.pcsourse;
    assign pcwrite  = w_ctl.pcwrite;
    assign pccen    = w_ctl.pccen;
    assign irwrite  = w_ctl.irwrite;
    assign regwen   = w_ctl.regwen;
    assign mdrwrite = w_ctl.mdrwrite;
    assign memwrite = w_ctl.memwrite;
    assign wbsel    = w_ctl.wbsel;
    assign immsel   = w_ctl.immsel;
    assign asel     = w_ctl.asel;
    assign bsel     = w_ctl.bsel;
    assign alusel   = w_ctl.alusel;
    assign illegal  = w_ctl.illegal;
    assign instret  = r_instret;

endmodule

// File: tb/tb_rv_ctl.sv
// Randomized bench for rv_ctl: per-instruction cycle schedule model.
// Honours RV_CTL_ILLEGAL_HALT_EN for the illegal-instruction phase.
module tb_rv_ctl;

    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3;
    localparam int K_BR = 4, K_JAL = 5, K_ILL = 6;

    localparam logic [31:0] I_ADD = 32'h002081B3;
    localparam logic [31:0] I_LW  = 32'h0080A283;
    localparam logic [31:0] I_SW  = 32'h0050A623;
    localparam logic [31:0] I_BEQ = 32'h00000063;
    localparam logic [31:0] I_BNE = 32'h00001063;
    localparam logic [31:0] I_JAL = 32'h010000EF;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        zero;
    logic        pcsourse, pcwrite, pccen, irwrite, regwen;
    logic        mdrwrite, memwrite, asel, bsel, illegal;
    logic [1:0]  wbsel, immsel;
    logic [3:0]  alusel;
    logic [31:0] instret;

    int          total = 0;
    int          bad = 0;
    logic [31:0] model_cnt;
    logic [17:0] w_got;

    always #5 clk = ~clk;

    rv_ctl #(.DPWIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .instr    (instr),
        .zero     (zero),
        .pcsourse (pcsourse),
        .pcwrite  (pcwrite),
        .pccen    (pccen),
        .irwrite  (irwrite),
        .regwen   (regwen),
        .mdrwrite (mdrwrite),
        .memwrite (memwrite),
        .wbsel    (wbsel),
        .immsel   (immsel),
        .asel     (asel),
        .bsel     (bsel),
        .alusel   (alusel),
        .illegal  (illegal),
        .instret  (instret)
    );

    assign w_got = {pcsourse, pcwrite, pccen, irwrite, regwen, mdrwrite,
                    memwrite, wbsel, immsel, asel, bsel, alusel, illegal};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int kind_of(input logic [31:0] ins);
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = ins[14:12];
        f7 = ins[31:25];
        case (ins[6:0])
            7'b0110011: return (f7 == 7'h00 || (f7 == 7'h20 &&
                               (f3 == 3'd0 || f3 == 3'd5))) ? K_R : K_ILL;
            7'b0010011: return ((f3 == 3'd1 || f3 == 3'd5) && f7 != 7'h00)
                               ? K_ILL : K_I;
            7'b0000011: return (f3 == 3'd2) ? K_LW : K_ILL;
            7'b0100011: return (f3 == 3'd2) ? K_SW : K_ILL;
            7'b1100011: return (f3 < 3'd2) ? K_BR : K_ILL;
            7'b1101111: return K_JAL;
            default:    return K_ILL;
        endcase
    endfunction

    function automatic int ncyc(input int kind);
        case (kind)
            K_R, K_I, K_SW: return 4;
            K_LW:           return 5;
            K_BR, K_JAL:    return 3;
            default:        return 2;
        endcase
    endfunction

    // ALU codes: ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9
    function automatic logic [3:0] alu_of(input logic [31:0] ins);
        logic alt;
        alt = (ins[6:0] == 7'b0110011) && ins[30];
        case (ins[14:12])
            3'd0: return alt ? 4'd1 : 4'd0;
            3'd1: return 4'd2;
            3'd2: return 4'd3;
            3'd3: return 4'd4;
            3'd4: return 4'd5;
            3'd5: return alt ? 4'd7 : 4'd6;
            3'd6: return 4'd8;
            default: return 4'd9;
        endcase
    endfunction

    function automatic logic [17:0] exp_cycle(input logic [31:0] ins,
                                              input int k, input logic z);
        logic pcs, pcw, pcc, irw, rwe, mdw, mw, a, b, ill;
        logic [1:0] wb, im;
        logic [3:0] alu;
        int kind;
        {pcs, pcw, pcc, irw, rwe, mdw, mw, a, b, ill} = '0;
        wb = 2'd0;
        im = 2'd0;
        alu = 4'd0;
        kind = kind_of(ins);
        if (k == 0) begin
            {irw, pcc, pcw} = 3'b111;
        end else if (k == 1) begin
            a = 1'b1;
            b = 1'b1;
            im = (ins[6:0] == 7'b1101111) ? 2'd0 : 2'd1;
            ill = (kind == K_ILL);
        end else begin
            case (kind)
                K_R, K_I: begin
                    if (k == 2) begin
                        alu = alu_of(ins);
                        if (kind == K_I) begin
                            b = 1'b1;
                            im = 2'd3;
                        end
                    end else begin
                        wb = 2'd1;
                        rwe = 1'b1;
                    end
                end
                K_LW: begin
                    if (k == 2) begin
                        b = 1'b1;
                        im = 2'd3;
                    end else if (k == 3) mdw = 1'b1;
                    else rwe = 1'b1;
                end
                K_SW: begin
                    if (k == 2) begin
                        b = 1'b1;
                        im = 2'd2;
                    end else mw = 1'b1;
                end
                K_BR: begin
                    alu = 4'd1;
                    pcs = 1'b1;
                    pcw = ins[12] ? !z : z;
                end
                K_JAL: begin
                    wb = 2'd2;
                    {rwe, pcw, pcs} = 3'b111;
                end
                default: ;
            endcase
        end
        return {pcs, pcw, pcc, irw, rwe, mdw, mw, wb, im, a, b, alu, ill};
    endfunction

    function automatic logic [31:0] gen();
        logic [31:0] r;
        logic [6:0]  f7;
        logic [2:0]  f3;
        r = $urandom;
        case ($urandom_range(0, 3))
            0, 1:    f7 = 7'h00;
            2:       f7 = 7'h20;
            default: f7 = r[31:25];
        endcase
        f3 = ($urandom_range(0, 3) == 0) ? r[14:12] : 3'd2;
        case ($urandom_range(0, 6))
            0: return {f7, r[24:12], r[11:7], 7'b0110011};
            1: return {f7, r[24:7], 7'b0010011};
            2: return {r[31:15], f3, r[11:7], 7'b0000011};
            3: return {r[31:15], f3, r[11:7], 7'b0100011};
            4: begin
                if ($urandom_range(0, 2) != 0) f3 = {2'b00, r[20]};
                return {r[31:15], f3, r[11:7], 7'b1100011};
            end
            5: return {r[31:7], 7'b1101111};
            default: return r;
        endcase
    endfunction

    task automatic run_instr(input logic [31:0] ins, input int abort_at);
        int kind;
        int n;
        kind = kind_of(ins);
        n = ncyc(kind);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            instr = ins;
            zero = 1'($urandom);
            #1;
            if (k == abort_at) begin
                rst = 1'b1;
                #1;
                chk("rst_mid", {14'b0, w_got}, 32'h0);
                @(posedge clk);
                #1;
                rst = 1'b0;
                model_cnt = '0;
                return;
            end
            if (k == 0) chk("instret", instret, model_cnt);
            chk($sformatf("ctl %h k%0d", ins, k), {14'b0, w_got},
                {14'b0, exp_cycle(ins, k, zero)});
        end
        if (kind != K_ILL) model_cnt = model_cnt + 32'd1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [31:0] ins;
        rst = 1'b1;
        instr = '0;
        zero = 1'b0;
        model_cnt = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_out", {14'b0, w_got}, 32'h0);
        chk("rst_instret", instret, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_instr(I_ADD, -1);
        run_instr(I_LW, -1);
        run_instr(I_SW, -1);
        repeat (3) begin
            run_instr(I_BEQ, -1);
            run_instr(I_BNE, -1);
        end
        run_instr(I_JAL, -1);
`ifndef RV_CTL_ILLEGAL_HALT_EN
        run_instr(32'h4010D093, -1);
`endif

        repeat (250) begin
            ins = gen();
`ifdef RV_CTL_ILLEGAL_HALT_EN
            while (kind_of(ins) == K_ILL) ins = gen();
`endif
            run_instr(ins, -1);
        end

        run_instr(I_LW, 3);
        run_instr(I_ADD, -1);

        run_instr(32'hFFFFFFFF, -1);
`ifdef RV_CTL_ILLEGAL_HALT_EN
        repeat (20) begin
            @(negedge clk);
            zero = 1'($urandom);
            #1;
            chk("halt", {14'b0, w_got}, 32'h1);
        end
        chk("halt_instret", instret, model_cnt);
`else
        run_instr(I_ADD, -1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
